div_sched: RTL and testbench

//  Oldest-first scheduler for the single shared multi-cycle divide unit. Picks among the

---
 rtl/div_sched_if.sv | 30 +++
 rtl/div_sched.sv | 136 +++++++++++++
 tb/tb_div_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_sched_if.sv
// Signal bundle between the divide scheduler and the commit window, the shared
// divide unit and the result write port.
interface div_sched_if #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5
);
  logic [NCOMMIT-1:0]  req;
  logic [NCOMMIT-1:0]  kill;
  logic [NCOMMIT-1:0]  grant;
  logic [LNCOMMIT-1:0] commit_head;
  logic [LNCOMMIT-1:0] start_slot;
  logic [LNCOMMIT-1:0] wb_slot;
  logic                start;
  logic                unit_done;
  logic                abort;
  logic                wb_valid;
  logic                wb_ready;
  logic                busy;
  logic                err;

  modport master (
    output req, commit_head, kill, unit_done, wb_ready,
    input  start, start_slot, grant, abort, wb_valid, wb_slot, busy, err
  );

  modport slave (
    input  req, commit_head, kill, unit_done, wb_ready,
    output start, start_slot, grant, abort, wb_valid, wb_slot, busy, err
  );
endinterface

// File: rtl/div_sched.sv
// Oldest-first issue scheduler for the shared multi-cycle divider; tracks the single
// in-flight op through completion, write-back, flush kill and watchdog abort.
//
//  state  | meaning
//  S_IDLE | nothing in flight, looking for the oldest ready divide
//  S_RUN  | op issued to the divider, waiting for unit_done
//  S_WB   | result held on wb_valid/wb_slot until the write port takes it
module div_sched #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int TIMEOUT  = 64,
  parameter int LTIMEOUT = 7
) (
  input logic        clk,
  input logic        reset,
  div_sched_if.slave io
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [LTIMEOUT-1:0] TMO_LAST = LTIMEOUT'(TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic [LNCOMMIT-1:0] cur_q, cur_d;
  logic [LTIMEOUT-1:0] cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [LNCOMMIT-1:0] start_slot_q, start_slot_d;
  logic [NCOMMIT-1:0]  grant_q, grant_d;
  logic                abort_q, abort_d;
  logic                wb_valid_q, wb_valid_d;
  logic [LNCOMMIT-1:0] wb_slot_q, wb_slot_d;
  logic                err_q, err_d;

  logic                found;
  logic [LNCOMMIT-1:0] sel;
  logic [LNCOMMIT-1:0] idx;

  // Walk from the head downward in age order; scanning i high-to-low leaves the
  // smallest offset (oldest slot) as the final winner. idx wraps on its own width.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = NCOMMIT - 1; i >= 0; i--) begin
      idx = io.commit_head + LNCOMMIT'(i);
      if (io.req[idx] && !io.kill[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    start_slot_d = start_slot_q;
    grant_d      = '0;
    abort_d      = 1'b0;
    wb_valid_d   = wb_valid_q;
    wb_slot_d    = wb_slot_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          start_d      = 1'b1;
          start_slot_d = sel;
          grant_d      = NCOMMIT'(1) << sel;
          cur_d        = sel;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // A kill racing the completion needs no abort: the unit has already let go.
        if (io.kill[cur_q]) begin
          abort_d = ~io.unit_done;
          state_d = S_IDLE;
        end else if (io.unit_done) begin
          wb_valid_d = 1'b1;
          wb_slot_d  = cur_q;
          state_d    = S_WB;
        end else if (cnt_q == TMO_LAST) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if ((wb_valid_q && io.wb_ready) || io.kill[cur_q]) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      start_slot_q <= '0;
      grant_q      <= '0;
      abort_q      <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_slot_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      start_slot_q <= start_slot_d;
      grant_q      <= grant_d;
      abort_q      <= abort_d;
      wb_valid_q   <= wb_valid_d;
      wb_slot_q    <= wb_slot_d;
      err_q        <= err_d;
    end
  end

  assign io.start      = start_q;
  assign io.start_slot = start_slot_q;
  assign io.grant      = grant_q;
  assign io.abort      = abort_q;
  assign io.wb_valid   = wb_valid_q;
  assign io.wb_slot    = wb_slot_q;
  assign io.err        = err_q;
  assign io.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed scenarios plus random traffic, all outputs compared
// every cycle against a transaction-level reference of the scheduler.
module tb_div_sched;
  localparam int N  = 32;
  localparam int LN = 5;
  localparam int TO = 64;

  logic clk;
  logic rst;

  div_sched_if #(.NCOMMIT(N), .LNCOMMIT(LN)) bus ();

  div_sched #(.NCOMMIT(N), .LNCOMMIT(LN), .TIMEOUT(TO), .LTIMEOUT(7)) dut (
    .clk   (clk),
    .reset (rst),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference: one op "in flight" (m_run) or "awaiting write port" (m_wb)
  bit          m_run, m_wb;
  int          m_age, m_cur;
  bit          m_start, m_abort, m_wbv, m_err;
  int          m_slot, m_wbs;
  logic [31:0] m_grant;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int oldest(input logic [31:0] rq, input logic [31:0] kl, input int head);
    for (int k = 0; k < N; k++) begin
      int s;
      s = (head + k) % N;
      if (rq[s] && !kl[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int s;
    m_start = 0;
    m_grant = '0;
    m_abort = 0;
    if (rst) begin
      m_run = 0; m_wb = 0; m_age = 0; m_cur = 0;
      m_slot = 0; m_wbv = 0; m_wbs = 0; m_err = 0;
    end else if (!m_run && !m_wb) begin
      s = oldest(bus.req, bus.kill, int'(bus.commit_head));
      if (s >= 0) begin
        m_start = 1; m_slot = s; m_grant = 32'(1) << s;
        m_cur = s; m_age = 0; m_run = 1;
      end
    end else if (m_run) begin
      if (bus.kill[m_cur]) begin
        m_run = 0; m_abort = !bus.unit_done;
      end else if (bus.unit_done) begin
        m_run = 0; m_wb = 1; m_wbv = 1; m_wbs = m_cur;
      end else if (m_age == TO - 1) begin
        m_run = 0; m_abort = 1; m_err = 1;
      end else begin
        m_age++;
      end
    end else begin
      if (bus.wb_ready || bus.kill[m_cur]) begin
        m_wb = 0; m_wbv = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("start",      64'(bus.start),      64'(m_start));
    chk("start_slot", 64'(bus.start_slot), 64'(m_slot));
    chk("grant",      64'(bus.grant),      64'(m_grant));
    chk("abort",      64'(bus.abort),      64'(m_abort));
    chk("wb_valid",   64'(bus.wb_valid),   64'(m_wbv));
    chk("wb_slot",    64'(bus.wb_slot),    64'(m_wbs));
    chk("busy",       64'(bus.busy),       64'(m_run || m_wb));
    chk("err",        64'(bus.err),        64'(m_err));
  endtask

  task automatic clear_in();
    bus.req = '0; bus.kill = '0; bus.unit_done = 0; bus.wb_ready = 0;
  endtask

  task automatic to_idle();
    clear_in();
    bus.kill = '1;
    tick();
    bus.kill = '0;
    tick();
  endtask

  task automatic issue(input int slot);
    clear_in();
    bus.commit_head = '0;
    bus.req = 32'(1) << slot;
    tick();
    chk("issue_start", 64'(bus.start), 64'd1);
    chk("issue_slot",  64'(bus.start_slot), 64'(slot));
    bus.req = '0;
  endtask

  initial begin
    rst = 1;
    bus.commit_head = '0;
    clear_in();
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err",  64'(bus.err),  64'd0);
    rst = 0;

    // 1: basic issue
    bus.req = 32'h0000_0011;
    tick();
    chk("t1_start", 64'(bus.start), 64'd1);
    chk("t1_slot",  64'(bus.start_slot), 64'd0);
    chk("t1_grant", 64'(bus.grant), 64'h1);
    chk("t1_busy",  64'(bus.busy), 64'd1);
    to_idle();

    // 2: wrap-around selection
    bus.commit_head = 5'd30;
    bus.req = (32'(1) << 1) | (32'(1) << 31);
    tick();
    chk("t2_wrap", 64'(bus.start_slot), 64'd31);
    to_idle();
    bus.commit_head = 5'd30;
    bus.req  = (32'(1) << 1) | (32'(1) << 30);
    bus.kill = 32'(1) << 30;
    tick();
    chk("t2_killsel", 64'(bus.start_slot), 64'd1);
    chk("t2_grant",   64'(bus.grant), 64'h2);
    to_idle();

    // 3: kill in RUN
    issue(5);
    tick();
    tick();
    bus.kill = 32'(1) << 5;
    tick();
    chk("t3_abort", 64'(bus.abort), 64'd1);
    chk("t3_busy",  64'(bus.busy), 64'd0);
    bus.kill = '0;
    tick();
    chk("t3_abort_once", 64'(bus.abort), 64'd0);
    chk("t3_no_wb",      64'(bus.wb_valid), 64'd0);

    // 4: write-back backpressure and back-to-back issue
    issue(7);
    bus.unit_done = 1;
    tick();
    bus.unit_done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_wbv_hold",  64'(bus.wb_valid), 64'd1);
      chk("t4_wbs_hold",  64'(bus.wb_slot), 64'd7);
    end
    bus.req = 32'(1) << 9;
    bus.wb_ready = 1;
    tick();
    chk("t4_wbv_drop", 64'(bus.wb_valid), 64'd0);
    chk("t4_no_start", 64'(bus.start), 64'd0);
    bus.wb_ready = 0;
    tick();
    chk("t4_b2b_start", 64'(bus.start), 64'd1);
    chk("t4_b2b_slot",  64'(bus.start_slot), 64'd9);
    to_idle();

    // 5: kill and done together
    issue(3);
    bus.kill = 32'(1) << 3;
    bus.unit_done = 1;
    tick();
    chk("t5_abort", 64'(bus.abort), 64'd0);
    chk("t5_wbv",   64'(bus.wb_valid), 64'd0);
    chk("t5_busy",  64'(bus.busy), 64'd0);
    clear_in();
    tick();

    // 6: watchdog
    issue(2);
    for (int k = 1; k < TO; k++) tick();
    chk("t6_pre_abort", 64'(bus.abort), 64'd0);
    chk("t6_pre_busy",  64'(bus.busy), 64'd1);
    tick();
    chk("t6_abort", 64'(bus.abort), 64'd1);
    chk("t6_err",   64'(bus.err), 64'd1);
    bus.req = 32'(1) << 4;
    tick();
    chk("t6_reissue", 64'(bus.start_slot), 64'd4);
    chk("t6_sticky",  64'(bus.err), 64'd1);
    bus.req = '0;
    rst = 1;
    tick();
    chk("t6_err_clr", 64'(bus.err), 64'd0);
    rst = 0;

    // random traffic
    begin
      bit quiet;
      int r;
      quiet = 0;
      for (int n = 0; n < 4000; n++) begin
        if (n % 300 == 0) quiet = ($urandom_range(0, 2) == 0);
        bus.commit_head = 5'($urandom_range(0, 31));
        bus.req = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
        bus.kill = '0;
        r = $urandom_range(0, 15);
        if (!quiet && r == 0)      bus.kill = 32'(1) << m_cur;
        else if (!quiet && r == 1) bus.kill = $urandom & $urandom & $urandom;
        bus.unit_done = !quiet && ($urandom_range(0, 5) == 0);
        bus.wb_ready  = 1'($urandom_range(0, 1));
        rst = ($urandom_range(0, 799) == 0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
